// File: rtl/sig_proc_pkg.sv
// Shared definitions for the trigger-path pulse processors (expansioner/shrinker):
// FSM state encoding and a saturating counter increment.
package sig_proc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    ACTIVE = 2'd2
  } sig_state_t;

  // Increment val by one, holding at the largest value representable in 'width' bits.
  // Callers zero-extend their counter to 32 bits and truncate the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/signal_shrinker.sv
// Pulse shrinker / glitch filter: removes len_q cycles from the front of every
// high pulse, drops pulses no longer than len_q, and reports the full input
// width of each pulse with a one-cycle strobe.
module signal_shrinker
  import sig_proc_pkg::*;
#(
  parameter int MAX_SHRINK_LEN_WIDTH = 5,
  parameter int WIDTH_CNT_WIDTH      = 16   // must exceed MAX_SHRINK_LEN_WIDTH, at most 32
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic [MAX_SHRINK_LEN_WIDTH-1:0] SHRINK_LEN,
  input  logic                            SIG_IN,
  output logic                            SIG_OUT,
  output logic [WIDTH_CNT_WIDTH-1:0]      PULSE_WIDTH,
  output logic                            WIDTH_VALID,
  output logic                            PULSE_DROPPED
);

  localparam logic [WIDTH_CNT_WIDTH-1:0] CNT_ONE =
    {{(WIDTH_CNT_WIDTH-1){1'b0}}, 1'b1};

  sig_state_t                      state, state_nxt;
  logic                            sig_d;
  logic [WIDTH_CNT_WIDTH-1:0]      cnt, cnt_nxt, cnt_inc;
  logic [MAX_SHRINK_LEN_WIDTH-1:0] len_q, len_nxt;
  logic [WIDTH_CNT_WIDTH-1:0]      len_ext;
  logic                            sig_out_nxt;
  logic [WIDTH_CNT_WIDTH-1:0]      pulse_width_nxt;
  logic                            width_valid_nxt;
  logic                            pulse_dropped_nxt;

  assign cnt_inc = WIDTH_CNT_WIDTH'(sat_inc(32'(cnt), WIDTH_CNT_WIDTH));
  assign len_ext = {{(WIDTH_CNT_WIDTH-MAX_SHRINK_LEN_WIDTH){1'b0}}, len_q};

  // Input register plus FSM/counter/output registers; all cleared asynchronously.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sig_d         <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      len_q         <= '0;
      SIG_OUT       <= 1'b0;
      PULSE_WIDTH   <= '0;
      WIDTH_VALID   <= 1'b0;
      PULSE_DROPPED <= 1'b0;
    end else begin
      sig_d         <= SIG_IN;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      len_q         <= len_nxt;
      SIG_OUT       <= sig_out_nxt;
      PULSE_WIDTH   <= pulse_width_nxt;
      WIDTH_VALID   <= width_valid_nxt;
      PULSE_DROPPED <= pulse_dropped_nxt;
    end
  end

  // Next-state and next-output logic; acts only on the registered input sig_d.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    len_nxt           = len_q;
    sig_out_nxt       = SIG_OUT;
    pulse_width_nxt   = PULSE_WIDTH;
    width_valid_nxt   = 1'b0;
    pulse_dropped_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sig_d) begin
          // Shrink length is latched here so mid-pulse changes wait for the next pulse.
          cnt_nxt = CNT_ONE;
          len_nxt = SHRINK_LEN;
          if (SHRINK_LEN == '0) begin
            state_nxt   = ACTIVE;
            sig_out_nxt = 1'b1;
          end else begin
            state_nxt = QUAL;
          end
        end
      end
      QUAL: begin
        if (sig_d) begin
          cnt_nxt = cnt_inc;
          if (cnt == len_ext) begin
            state_nxt   = ACTIVE;
            sig_out_nxt = 1'b1;
          end
        end else begin
          state_nxt         = IDLE;
          pulse_width_nxt   = cnt;
          width_valid_nxt   = 1'b1;
          pulse_dropped_nxt = 1'b1;
          cnt_nxt           = '0;
        end
      end
      ACTIVE: begin
        if (sig_d) begin
          cnt_nxt = cnt_inc;
        end else begin
          state_nxt         = IDLE;
          sig_out_nxt       = 1'b0;
          pulse_width_nxt   = cnt;
          width_valid_nxt   = 1'b1;
          pulse_dropped_nxt = 1'b0;
          cnt_nxt           = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        sig_out_nxt = 1'b0;
        cnt_nxt     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_signal_shrinker.sv
// Directed testbench for signal_shrinker: drives hand-built pulse trains and
// compares observed output widths, latencies and width strobes against
// hand-computed values.
module tb_signal_shrinker;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [4:0]  SHRINK_LEN = 5'd4;
  logic        SIG_IN = 1'b0;
  logic        SIG_OUT;
  logic [15:0] PULSE_WIDTH;
  logic        WIDTH_VALID;
  logic        PULSE_DROPPED;

  signal_shrinker #(
    .MAX_SHRINK_LEN_WIDTH(5),
    .WIDTH_CNT_WIDTH(16)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .SHRINK_LEN(SHRINK_LEN),
    .SIG_IN(SIG_IN),
    .SIG_OUT(SIG_OUT),
    .PULSE_WIDTH(PULSE_WIDTH),
    .WIDTH_VALID(WIDTH_VALID),
    .PULSE_DROPPED(PULSE_DROPPED)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Edge counter
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Cumulative output observer, sampled on the falling edge
  int hi_cnt = 0;
  int rises = 0;
  int rise_cyc = 0;
  int nvalid = 0;
  int last_pw = 0;
  int last_dr = 0;
  int orphan = 0;
  logic prev_out = 1'b0;
  always @(negedge CLK) begin
    if (SIG_OUT && !prev_out) begin
      rises++;
      rise_cyc = cyc;
    end
    if (SIG_OUT) hi_cnt++;
    if (WIDTH_VALID) begin
      nvalid++;
      last_pw = int'(PULSE_WIDTH);
      last_dr = int'(PULSE_DROPPED);
    end
    if (PULSE_DROPPED && !WIDTH_VALID) orphan++;
    prev_out = SIG_OUT;
  end

  int in_rise = 0;
  int hi0, nv0, rs0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hold SIG_IN at lvl for n rising edges; returns 1 time unit after the last edge.
  task automatic hold(input logic lvl, input int n);
    if (lvl && !SIG_IN) in_rise = cyc;
    SIG_IN = lvl;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    hi0 = hi_cnt;
    nv0 = nvalid;
    rs0 = rises;
  endtask

  initial begin
    // Reset state
    repeat (5) @(posedge CLK);
    #1;
    chk("rst_sig_out", int'(SIG_OUT), 0);
    chk("rst_pulse_width", int'(PULSE_WIDTH), 0);
    chk("rst_width_valid", int'(WIDTH_VALID), 0);
    chk("rst_pulse_dropped", int'(PULSE_DROPPED), 0);
    RESETN = 1'b1;
    hold(1'b0, 2);

    // Basic 20-cycle pulse, shrink 4
    snap();
    hold(1'b1, 20);
    hold(1'b0, 20);
    chk("t1_out_width", hi_cnt - hi0, 16);
    chk("t1_rise_latency", rise_cyc - in_rise, 6);
    chk("t1_strobes", nvalid - nv0, 1);
    chk("t1_pulse_width", last_pw, 20);
    chk("t1_dropped", last_dr, 0);

    // Boundary: width == shrink is suppressed, width == shrink+1 gives one cycle
    snap();
    hold(1'b1, 4);
    hold(1'b0, 10);
    chk("t2a_out_width", hi_cnt - hi0, 0);
    chk("t2a_strobes", nvalid - nv0, 1);
    chk("t2a_pulse_width", last_pw, 4);
    chk("t2a_dropped", last_dr, 1);
    snap();
    hold(1'b1, 5);
    hold(1'b0, 10);
    chk("t2b_out_width", hi_cnt - hi0, 1);
    chk("t2b_pulse_width", last_pw, 5);
    chk("t2b_dropped", last_dr, 0);

    // Expander-stretched pulse (20 + 4 cycles) through shrink 4
    snap();
    hold(1'b1, 24);
    hold(1'b0, 10);
    chk("t3_out_width", hi_cnt - hi0, 20);
    chk("t3_pulse_width", last_pw, 24);

    // Shrink 0, alternating 1-high/1-low pulses
    SHRINK_LEN = 5'd0;
    snap();
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 1);
      hold(1'b0, 1);
    end
    hold(1'b0, 10);
    chk("t4_out_high_cycles", hi_cnt - hi0, 3);
    chk("t4_out_rises", rises - rs0, 3);
    chk("t4_strobes", nvalid - nv0, 3);
    chk("t4_pulse_width", last_pw, 1);
    chk("t4_rise_latency", rise_cyc - in_rise, 2);

    // Shrink length changed mid-pulse applies only to the next pulse
    SHRINK_LEN = 5'd4;
    snap();
    hold(1'b1, 3);
    SHRINK_LEN = 5'd10;
    hold(1'b1, 17);
    hold(1'b0, 10);
    chk("t5a_out_width", hi_cnt - hi0, 16);
    chk("t5a_pulse_width", last_pw, 20);
    snap();
    hold(1'b1, 20);
    hold(1'b0, 10);
    chk("t5b_out_width", hi_cnt - hi0, 10);
    chk("t5b_pulse_width", last_pw, 20);

    // Reset in the middle of an active pulse, input stays high across release
    SHRINK_LEN = 5'd2;
    hold(1'b1, 10);
    nv0 = nvalid;
    RESETN = 1'b0;
    #1;
    chk("t6_async_sig_out", int'(SIG_OUT), 0);
    chk("t6_async_pulse_width", int'(PULSE_WIDTH), 0);
    chk("t6_async_width_valid", int'(WIDTH_VALID), 0);
    repeat (3) @(posedge CLK);
    #1;
    RESETN = 1'b1;
    hi0 = hi_cnt;
    hold(1'b1, 8);
    hold(1'b0, 10);
    chk("t6_strobes", nvalid - nv0, 1);
    chk("t6_pulse_width", last_pw, 8);
    chk("t6_dropped", last_dr, 0);
    chk("t6_out_width", hi_cnt - hi0, 6);

    // Counter saturation on a very long pulse
    SHRINK_LEN = 5'd0;
    snap();
    hold(1'b1, 65540);
    hold(1'b0, 10);
    chk("t7_pulse_width_sat", last_pw, 65535);
    chk("t7_out_width", hi_cnt - hi0, 65540);
    chk("t7_strobes", nvalid - nv0, 1);

    // PULSE_DROPPED never seen without WIDTH_VALID
    chk("orphan_dropped", orphan, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signal_shrinker.md
Name: signal_shrinker

Overview:
Inverse companion of signal_expansioner: trims a configurable number of cycles (SHRINK_LEN) from the front of each high pulse and suppresses pulses no longer than SHRINK_LEN (glitch filter).
Measures the full input width of every pulse and reports it with a one-cycle valid strobe, for trigger-width monitoring.
It sits after signal_expansioner in the same single-clock trigger path, or stands alone on raw discriminator outputs.

Parameters:
MAX_SHRINK_LEN_WIDTH, 5, width of SHRINK_LEN; max shrink = 2^MAX_SHRINK_LEN_WIDTH-1
WIDTH_CNT_WIDTH, 16, width of run counter and PULSE_WIDTH; must be > MAX_SHRINK_LEN_WIDTH

Ports:
CLK  in  1  single clock; all logic on posedge
RESETN  in  1  asynchronous, active-low reset
SHRINK_LEN  in  MAX_SHRINK_LEN_WIDTH  cycles removed from pulse front; sampled once per pulse
SIG_IN  in  1  input level, synchronous to CLK
SIG_OUT  out  1  shrunk pulse, registered
PULSE_WIDTH  out  WIDTH_CNT_WIDTH  full width of the last completed input pulse, saturating
WIDTH_VALID  out  1  one-cycle strobe: PULSE_WIDTH updated
PULSE_DROPPED  out  1  one-cycle strobe with WIDTH_VALID when the pulse was fully suppressed

Behaviour:
- Interface: one clock CLK; reset RESETN is asynchronous, active-low.
- Reset (async assert): sig_d=0, state=IDLE, cnt=0, len_q=0, SIG_OUT=0, PULSE_WIDTH=0, WIDTH_VALID=0, PULSE_DROPPED=0.
- Stage 1: sig_d <= SIG_IN every edge. The FSM acts only on sig_d.
- FSM states: IDLE, QUAL (counting, SIG_OUT=0), ACTIVE (SIG_OUT=1).
- IDLE, sig_d=1: cnt<=1, len_q<=SHRINK_LEN. If SHRINK_LEN==0, go to ACTIVE with SIG_OUT<=1; otherwise go to QUAL.
- IDLE, sig_d=0: hold.
- QUAL, sig_d=1: cnt<=sat(cnt+1). If cnt==len_q, go to ACTIVE with SIG_OUT<=1.
- QUAL, sig_d=0: go to IDLE; PULSE_WIDTH<=cnt, WIDTH_VALID<=1, PULSE_DROPPED<=1, cnt<=0.
- ACTIVE, sig_d=1: cnt<=sat(cnt+1).
- ACTIVE, sig_d=0: go to IDLE; SIG_OUT<=0, PULSE_WIDTH<=cnt, WIDTH_VALID<=1, PULSE_DROPPED<=0, cnt<=0.
- Strobes WIDTH_VALID and PULSE_DROPPED are 0 in every other cycle.
- Timing: let e0 be the edge where sig_d first reads 1, for an input pulse of W cycles.
  - SIG_OUT rises at e0+1+len_q and falls at e0+W+1.
  - Output width = W-len_q when W>len_q; otherwise no output pulse.
  - SIG_IN-to-SIG_OUT latency is 2 edges on both rising and falling edges.
- SHRINK_LEN changes mid-pulse are ignored; the new value applies from the next pulse.
- Saturation: cnt stops at 2^WIDTH_CNT_WIDTH-1. A long pulse stays ACTIVE and reports the saturated value.
- Back-to-back pulses with a 1-cycle low gap: the falling strobe and the return to IDLE happen on one edge. The next high sig_d is seen on the following edge, so no pulse is lost or merged.
- SIG_IN held constantly high after reset release: counted as a new pulse from the first sampled high.
- Reset mid-pulse: everything clears immediately; no WIDTH_VALID is emitted for the aborted pulse.

Decomposition:
- Shared package (sig_proc_pkg): the state encoding constants (IDLE/QUAL/ACTIVE) and a saturating-increment function. These are shared with signal_expansioner's counter.
- Single module; no sub-module warranted.

Test Plan:
1. Reset 5 cycles, SHRINK_LEN=4, SIG_IN high 20 then low 20 -> SIG_OUT high 16 cycles, rising 6 edges after SIG_IN rises; one WIDTH_VALID with PULSE_WIDTH=20, PULSE_DROPPED=0.
2. SHRINK_LEN=4, pulses of width 4 and then 5 -> first: no SIG_OUT, WIDTH_VALID with PULSE_WIDTH=4 and PULSE_DROPPED=1; second: SIG_OUT high 1 cycle, PULSE_WIDTH=5.
3. Chain signal_expansioner(EXTEND_LEN=4) -> signal_shrinker(SHRINK_LEN=4), 20-cycle input pulse -> SIG_OUT width 20, PULSE_WIDTH=24.
4. SHRINK_LEN=0, pulses 1-high/1-low repeated 3 times -> SIG_OUT reproduces the pattern delayed 2 edges; 3 strobes, each PULSE_WIDTH=1.
5. SHRINK_LEN changed 4->10 at cycle 3 of a 20-cycle pulse -> SIG_OUT width 16; next 20-cycle pulse gives width 10.
6. Assert RESETN low at cycle 10 of a 20-cycle pulse, release with SIG_IN still high for 8 more cycles (SHRINK_LEN=2) -> outputs clear asynchronously; no strobe for the aborted pulse; new pulse reports PULSE_WIDTH equal to the sampled high cycles after release, with SIG_OUT width 2 less.
